// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Fetch/exec controller for the 4-bit computer. Holds the PC,
//                latches ROM instructions and decodes operand-mux, register
//                load and RAM write controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int PC_W   = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [7:0]        rom_data,
    input  logic              carry,
    output logic [PC_W-1:0]   rom_addr,
    output logic [DATA_W-1:0] imm,
    output logic              mux_sel,
    output logic              mux_enable,
    output logic              ld_a,
    output logic              ld_b,
    output logic              ram_we,
    output logic              halted
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_exec  = 2'd2;
    localparam logic [1:0] c_st_halt  = 2'd3;

    localparam logic [3:0] c_op_ldai = 4'h1;
    localparam logic [3:0] c_op_ldbi = 4'h2;
    localparam logic [3:0] c_op_ldam = 4'h3;
    localparam logic [3:0] c_op_ldbm = 4'h4;
    localparam logic [3:0] c_op_sta  = 4'h6;
    localparam logic [3:0] c_op_jmp  = 4'h7;
    localparam logic [3:0] c_op_jnc  = 4'h8;
    localparam logic [3:0] c_op_hlt  = 4'hF;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_jump_tgt;
    logic [7:0]      r_ir;
    logic [3:0]      w_opcode;

    assign w_opcode   = r_ir[7:4];
    assign w_jump_tgt = PC_W'(r_ir[DATA_W-1:0]);
    assign rom_addr   = r_pc;
    assign imm        = r_ir[DATA_W-1:0];
    assign halted     = (r_state == c_st_halt);

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        mux_sel      = 1'b0;
        mux_enable   = 1'b0;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        ram_we       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (run) w_state_next = c_st_fetch;
            end
            c_st_fetch: begin
                w_state_next = run ? c_st_exec : c_st_idle;
            end
            c_st_exec: begin
                // Every instruction advances the PC except taken jumps and HLT.
                w_state_next = c_st_fetch;
                w_pc_next    = r_pc + 1'b1;
                case (w_opcode)
                    c_op_ldai: begin mux_enable = 1'b1; ld_a = 1'b1; end
                    c_op_ldbi: begin mux_enable = 1'b1; ld_b = 1'b1; end
                    c_op_ldam: begin mux_enable = 1'b1; mux_sel = 1'b1; ld_a = 1'b1; end
                    c_op_ldbm: begin mux_enable = 1'b1; mux_sel = 1'b1; ld_b = 1'b1; end
                    c_op_sta:  ram_we = 1'b1;
                    c_op_jmp:  w_pc_next = w_jump_tgt;
                    c_op_jnc:  if (!carry) w_pc_next = w_jump_tgt;
                    c_op_hlt: begin
                        w_pc_next    = r_pc;
                        w_state_next = c_st_halt;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_pc    <= '0;
            r_ir    <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (r_state == c_st_fetch && run) r_ir <= rom_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed and randomized bench for fetch_sequencer against a
//                behavioural instruction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [7:0] rom_data;
    logic       carry;
    logic [3:0] rom_addr;
    logic [3:0] imm;
    logic       mux_sel;
    logic       mux_enable;
    logic       ld_a;
    logic       ld_b;
    logic       ram_we;
    logic       halted;

    logic [7:0] rom [16];

    int n_cmp;
    int n_bad;

    // Model: phase 0 idle, 1 fetch, 2 exec, 3 halt.
    int         m_phase;
    int         m_pc;
    logic [7:0] m_ir;

    fetch_sequencer #(.PC_W(4), .DATA_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .rom_data   (rom_data),
        .carry      (carry),
        .rom_addr   (rom_addr),
        .imm        (imm),
        .mux_sel    (mux_sel),
        .mux_enable (mux_enable),
        .ld_a       (ld_a),
        .ld_b       (ld_b),
        .ram_we     (ram_we),
        .halted     (halted)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {mux_enable, mux_sel, ld_a, ld_b, ram_we}
    function automatic logic [4:0] exp_ctl(input int phase, input logic [7:0] ir);
        if (phase != 2) return 5'b00000;
        case (ir[7:4])
            4'h1:    return 5'b10100;
            4'h2:    return 5'b10010;
            4'h3:    return 5'b11100;
            4'h4:    return 5'b11010;
            4'h6:    return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic c, input logic rs);
        int op;
        if (rs) begin
            m_phase = 0; m_pc = 0; m_ir = 8'h00;
        end else begin
            case (m_phase)
                0: if (r) m_phase = 1;
                1: begin
                    if (r) begin m_ir = rom[m_pc]; m_phase = 2; end
                    else m_phase = 0;
                end
                2: begin
                    op = int'(m_ir[7:4]);
                    if (op == 15) m_phase = 3;
                    else begin
                        m_phase = 1;
                        if (op == 7 || (op == 8 && !c)) m_pc = int'(m_ir[3:0]);
                        else m_pc = (m_pc + 1) % 16;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic c, input logic rs);
        run = r; carry = c; rst = rs;
        @(posedge clk);
        model_edge(r, c, rs);
        #1;
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("imm", 32'(imm), 32'(m_ir[3:0]));
        chk("controls", 32'({mux_enable, mux_sel, ld_a, ld_b, ram_we}), 32'(exp_ctl(m_phase, m_ir)));
        chk("halted", 32'(halted), 32'(m_phase == 3));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_n(input int n, input logic c);
        for (int i = 0; i < n; i++) step(1'b1, c, 1'b0);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; run = 1'b0; carry = 1'b0;
        m_phase = 0; m_pc = 0; m_ir = 8'h00;
        fill_nop();

        // Reset state, then LDAI interrupted by reset mid-EXEC
        rom[0] = 8'h1F;
        do_reset();
        chk("reset_addr", 32'(rom_addr), 32'h0);
        chk("reset_halted", 32'(halted), 32'h0);
        run_n(2, 1'b0);
        chk("t1_ld_a_exec", 32'(ld_a), 32'h1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("t1_ld_a", 32'(ld_a), 32'h0);
        chk("t1_mux_en", 32'(mux_enable), 32'h0);
        chk("t1_addr", 32'(rom_addr), 32'h0);

        // LDAI 0x1F then LDBM 0x47
        rom[1] = 8'h47;
        do_reset();
        run_n(2, 1'b0);
        chk("t2_imm", 32'(imm), 32'hF);
        chk("t2_ctl", 32'({mux_enable, mux_sel, ld_a}), 32'b101);
        run_n(1, 1'b0);
        chk("t2_addr", 32'(rom_addr), 32'h1);
        run_n(1, 1'b0);
        chk("t3_ctl", 32'({mux_enable, mux_sel, ld_b, ld_a, ram_we}), 32'b11100);
        chk("t3_imm", 32'(imm), 32'h7);

        // JNC 0x85 at pc=3, JMP 0x7A at 5
        fill_nop();
        rom[3] = 8'h85; rom[5] = 8'h7A;
        do_reset();
        run_n(9, 1'b0);
        chk("t4_jnc_taken", 32'(rom_addr), 32'h5);
        run_n(2, 1'b0);
        chk("t4_jmp", 32'(rom_addr), 32'hA);
        do_reset();
        run_n(9, 1'b1);
        chk("t4_jnc_not_taken", 32'(rom_addr), 32'h4);

        // Wrap 15 -> 0
        fill_nop();
        do_reset();
        run_n(33, 1'b0);
        chk("t5_wrap", 32'(rom_addr), 32'h0);

        // HLT 0xF0 at pc=2, run toggling
        rom[2] = 8'hF0;
        do_reset();
        run_n(7, 1'b0);
        chk("t6_halted", 32'(halted), 32'h1);
        for (int i = 0; i < 10; i++) step(1'(i % 2), 1'($urandom_range(0, 1)), 1'b0);
        chk("t6_addr", 32'(rom_addr), 32'h2);

        // run dropped during FETCH keeps ir
        fill_nop();
        rom[0] = 8'h1F; rom[1] = 8'h2A;
        do_reset();
        run_n(3, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_idle_imm", 32'(imm), 32'hF);
        chk("t6_idle_ctl", 32'({mux_enable, ld_a, ld_b}), 32'h0);

        // Randomized programs and inputs
        for (int blk = 0; blk < 10; blk++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
            do_reset();
            for (int i = 0; i < 200; i++)
                step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
